// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard controller.
// Entry rd is stored at FWD_RD_W bits so one struct serves any AW up to that width.
package fwd_pkg;

    localparam int FWD_RD_W   = 8;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                we;
        logic                load;
    } fwd_entry_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match_prio.sv
// Per-source priority match over tracked writers: youngest matching stage wins.
// Purely combinational, zero latency; no flow control of its own.
module fwd_match_prio
    import fwd_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int SW    = fwd_sel_w(DEPTH)
) (
    input  logic [AW-1:0]          src,
    input  fwd_entry_t [DEPTH-1:0] ents,
    input  logic                   hold_s1,
    output logic [SW-1:0]          sel,
    output logic                   load_use
);

    logic [FWD_RD_W-1:0] src_x;

    assign src_x = FWD_RD_W'(src);

    // Oldest to youngest so the last hit (smallest stage) overwrites.
    always_comb begin
        sel      = SW'(FWD_SEL_RF);
        load_use = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ents[k].valid && ents[k].we && (ents[k].rd != '0) && (ents[k].rd == src_x)) begin
                if ((k == 0) && (ents[k].load || hold_s1)) begin
                    sel      = SW'(FWD_SEL_RF);
                    load_use = ents[k].load;
                end else begin
                    sel      = SW'(k + 1);
                    load_use = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding selects and load-use/multi-cycle stall from an internal writer pipeline; combinational outputs, no added latency.
// Stall holds PC and IF/ID; flush aborts the ID instruction and any multi-cycle op. FWD_STATS_EN adds saturating stall/forward counters.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int DEPTH   = 3,
    parameter int MC_LAT  = 4,
    parameter int SW      = fwd_sel_w(DEPTH)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_valid_i,
    input  logic [AW-1:0]                issue_rd_i,
    input  logic                         issue_we_i,
    input  logic                         issue_load_i,
    input  logic                         issue_mc_i,
    input  logic                         flush_i,
    input  logic [NUM_SRC*AW-1:0]        src_rs_i,
    output logic [NUM_SRC*SW-1:0]        fwd_sel_o,
    output logic                         stall_o,
    output logic                         mc_busy_o,
    output logic [$clog2(MC_LAT+1)-1:0]  mc_cnt_o
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                  stat_stall_o,
    output logic [31:0]                  stat_fwd_o
`endif
);

    localparam int CW = $clog2(MC_LAT + 1);

    fwd_entry_t [DEPTH-1:0] ents;
    fwd_entry_t             issue_ent;
    logic [CW-1:0]          mc_cnt;
    logic [NUM_SRC-1:0]     lu_vec;
    logic                   mc_active;
    logic                   accept;

    assign mc_active = (mc_cnt != '0);
    assign stall_o   = (|lu_vec) | mc_active;
    assign mc_busy_o = mc_active;
    assign mc_cnt_o  = mc_cnt;
    assign accept    = issue_valid_i & ~stall_o & ~flush_i;
    assign issue_ent = '{valid: 1'b1, rd: FWD_RD_W'(issue_rd_i), we: issue_we_i, load: issue_load_i};

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_port
        fwd_match_prio #(
            .AW    (AW),
            .DEPTH (DEPTH),
            .SW    (SW)
        ) u_match (
            .src      (src_rs_i[n*AW +: AW]),
            .ents     (ents),
            .hold_s1  (mc_active),
            .sel      (fwd_sel_o[n*SW +: SW]),
            .load_use (lu_vec[n])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ents   <= '0;
            mc_cnt <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 2; k--) begin
                ents[k] <= ents[k-1];
            end
            if (mc_active) begin
                // EX is occupied: stage 1 holds, a bubble enters stage 2.
                ents[1] <= '0;
                mc_cnt  <= mc_cnt - CW'(1);
            end else begin
                ents[1] <= ents[0];
                if (accept) begin
                    ents[0] <= issue_ent;
                    if (issue_mc_i) begin
                        mc_cnt <= CW'(MC_LAT - 1);
                    end
                end else begin
                    ents[0] <= '0;
                end
            end
            if (flush_i) begin
                ents[0] <= '0;
                mc_cnt  <= '0;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic any_fwd;

    assign any_fwd = |fwd_sel_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_stall_o <= '0;
            stat_fwd_o   <= '0;
        end else begin
            if (stall_o && (stat_stall_o != '1)) begin
                stat_stall_o <= stat_stall_o + 32'd1;
            end
            if (any_fwd && (stat_fwd_o != '1)) begin
                stat_fwd_o <= stat_fwd_o + 32'd1;
            end
        end
    end
`endif

endmodule
